// File: rtl/hash_data_ctrl.sv
// Hash-data sequencer: walks addresses 0..n-1 and packs one 13-bit word per address.
// Optional HASH_CTRL_ABORT_EN adds an i_abort input that returns any active run to IDLE.
module hash_data_ctrl #(
    parameter int MAX_WORDS = 757,
    parameter int MEM_LAT   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [10:0] i_degp,
`ifdef HASH_CTRL_ABORT_EN
    input  logic        i_abort,
`endif
    output logic        o_R1,
    output logic        o_R2,
    output logic        o_R3,
    output logic        o_R4,
    output logic        o_R5,
    output logic        o_busy,
    output logic        o_done
);
    localparam int              WW        = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [WW-1:0]   WAIT_LAST = WW'(MEM_LAT - 1);
    localparam logic [10:0]     MAX_N     = 11'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE
    } state_t;

    state_t        r_state, w_next;
    logic [10:0]   r_n, r_cnt;
    logic [WW-1:0] r_wait;
    logic          r_first;
    logic [10:0]   w_n_in;
    logic          w_abort;
    logic          w_accept;

`ifdef HASH_CTRL_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_n_in   = (i_degp > MAX_N) ? MAX_N : i_degp;
    // An abort arriving together with start in IDLE suppresses the start.
    assign w_accept = (r_state == S_IDLE) && i_start && !w_abort;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_cnt   <= '0;
            r_wait  <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_n     <= w_n_in;
                        r_cnt   <= '0;
                        r_first <= 1'b1;
                    end
                end
                S_ISSUE: r_wait <= '0;
                S_WAIT: begin
                    if (r_wait != WAIT_LAST)
                        r_wait <= r_wait + WW'(1);
                end
                S_CAPTURE: begin
                    if (!w_abort) begin
                        r_cnt   <= r_cnt + 11'd1;
                        r_first <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = (w_n_in == 11'd0) ? S_DONE : S_ISSUE;
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT:    if (r_wait == WAIT_LAST) w_next = S_CAPTURE;
            S_CAPTURE: w_next = (r_cnt + 11'd1 == r_n) ? S_DONE : S_ISSUE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_abort && r_state != S_IDLE)
            w_next = S_IDLE;
    end

    always_comb begin
        o_R1   = 1'b0;
        o_R2   = 1'b0;
        o_R3   = 1'b1;
        o_R4   = 1'b0;
        o_R5   = 1'b1;
        o_busy = 1'b1;
        o_done = 1'b0;
        case (r_state)
            S_IDLE:  o_busy = 1'b0;
            S_ISSUE: begin
                o_R2 = 1'b1;
                o_R3 = 1'b0;
            end
            S_WAIT:  o_R1 = 1'b1;
            S_CAPTURE: begin
                // An aborted capture must leave hash_data untouched.
                o_R1 = 1'b1;
                o_R4 = ~r_first;
                o_R5 = w_abort;
            end
            S_DONE: begin
                o_R1   = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_hash_data_ctrl.sv
// Bench for hash_data_ctrl: a behavioural datapath (i, address, memory, hash_data) driven by R1..R5,
// checked against packed-word expectations computed directly from memory contents.
module tb_hash_data_ctrl;
    localparam int HW    = 9841;
    localparam int LIMIT = 5000;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [10:0] i_degp = '0;
    logic        i_abort = 1'b0;
    logic        o_R1, o_R2, o_R3, o_R4, o_R5, o_busy, o_done;

    int checks = 0;
    int failures = 0;

    hash_data_ctrl dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_degp  (i_degp),
`ifdef HASH_CTRL_ABORT_EN
        .i_abort (i_abort),
`endif
        .o_R1    (o_R1),
        .o_R2    (o_R2),
        .o_R3    (o_R3),
        .o_R4    (o_R4),
        .o_R5    (o_R5),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    // Datapath the controller steers, with a one-cycle registered memory read.
    logic [12:0]   mem [0:2047];
    logic [10:0]   i_reg = '0;
    logic [10:0]   addr = '0;
    logic [12:0]   mem_out = '0;
    logic [HW-1:0] hash = '0;
    int n_cap = 0, n_first = 0, n_done = 0;

    always @(posedge i_clk) begin
        if (!o_R1) i_reg <= o_R2 ? i_reg + 11'd1 : 11'd0;
        if (!o_R3) addr <= i_reg;
        mem_out <= mem[addr];
        if (!o_R5) hash <= o_R4 ? {hash[HW-14:0], mem_out} : HW'(mem_out);
        if (!o_R5) n_cap <= n_cap + 1;
        if (!o_R5 && !o_R4) n_first <= n_first + 1;
        if (o_done) n_done <= n_done + 1;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_hash(input string tag, input logic [HW-1:0] exp);
        checks++;
        assert (hash === exp) else begin
            failures++;
            $error("FAIL %s observed_lo=%0h expected_lo=%0h", tag, hash[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [HW-1:0] pack(input int n);
        logic [HW-1:0] e;
        e = '0;
        for (int k = 0; k < n; k++) e = {e[HW-14:0], mem[k]};
        return e;
    endfunction

    function automatic logic [6:0] outs();
        return {o_R1, o_R2, o_R3, o_R4, o_R5, o_busy, o_done};
    endfunction

    // One complete run: latency, capture counts, single done pulse and packed contents.
    task automatic do_run(input int degp, input bit seq, input string tag);
        int n, cyc, c0, f0, d0;
        logic [HW-1:0] exp;
        n = (degp > 757) ? 757 : degp;
        for (int k = 0; k < n; k++) mem[k] = seq ? 13'(k + 1) : 13'($urandom);
        exp = (n == 0) ? hash : pack(n);
        c0 = n_cap; f0 = n_first; d0 = n_done;
        i_degp = 11'(degp);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_degp = 11'($urandom);
        cyc = 1;
        chk({tag, "_busy"}, 64'(o_busy), 64'd1);
        while (!o_done && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(n * 3 + 1));
        tick();
        chk({tag, "_idle_after"}, 64'(outs()), 64'b0010100);
        chk({tag, "_done_pulses"}, 64'(n_done - d0), 64'd1);
        chk({tag, "_captures"}, 64'(n_cap - c0), 64'(n));
        chk({tag, "_first_loads"}, 64'(n_first - f0), 64'(n > 0));
        chk_hash({tag, "_hash"}, exp);
    endtask

    initial begin
        int cyc, c0, f0, d0;
        logic [HW-1:0] exp, h0;

        for (int k = 0; k < 2048; k++) mem[k] = 13'($urandom);
        tick();
        tick();
        chk("reset_outputs", 64'(outs()), 64'b0010100);
        i_rst_n = 1'b1;
        tick();

        do_run(3, 1'b1, "seq3");
        chk("seq3_low39", 64'(hash[38:0]), {25'd0, 13'd1, 13'd2, 13'd3});
        do_run(0, 1'b0, "zero");
        do_run(2000, 1'b0, "clip");
        for (int r = 0; r < 3; r++) do_run(int'($urandom_range(1, 20)), 1'b0, "rand");

        // Mid-run start pulse is ignored; start held across DONE launches run 2.
        for (int k = 0; k < 4; k++) mem[k] = 13'($urandom);
        exp = pack(4);
        i_degp = 11'd4;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 1;
        while (!o_done && cyc < LIMIT) begin
            i_start = (cyc == 5 || cyc >= 11);
            tick();
            cyc++;
        end
        chk("b2b_run1_latency", 64'(cyc), 64'd13);
        chk_hash("b2b_run1_hash", exp);
        for (int k = 0; k < 3; k++) mem[k] = 13'($urandom);
        exp = pack(3);
        c0 = n_cap; f0 = n_first;
        i_degp = 11'd3;
        tick();
        chk("b2b_idle_between", 64'(o_busy), 64'd0);
        tick();
        i_start = 1'b0;
        chk("b2b_run2_started", 64'(o_busy), 64'd1);
        cyc = 1;
        while (!o_done && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        chk("b2b_run2_latency", 64'(cyc), 64'd10);
        chk("b2b_run2_first", 64'(n_first - f0), 64'd1);
        chk("b2b_run2_caps", 64'(n_cap - c0), 64'd3);
        chk_hash("b2b_run2_hash", exp);
        tick();

        // Reset mid-run: IDLE outputs, no done pulse.
        d0 = n_done;
        i_degp = 11'd10;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (6) tick();
        i_rst_n = 1'b0;
        tick();
        chk("rst_mid_first", 64'(outs()), 64'b0010100);
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("rst_mid_after", 64'(outs()), 64'b0010100);
        repeat (40) tick();
        chk("rst_mid_no_done", 64'(n_done - d0), 64'd0);
        do_run(7, 1'b0, "post_rst");

`ifdef HASH_CTRL_ABORT_EN
        for (int k = 0; k < 5; k++) mem[k] = 13'($urandom);
        d0 = n_done;
        i_degp = 11'd5;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 1;
        while (cyc < 6) begin
            tick();
            cyc++;
        end
        i_abort = 1'b1;
        #1;
        chk("abort_hold_r5", 64'(o_R5), 64'd1);
        h0 = hash;
        tick();
        i_abort = 1'b0;
        chk("abort_idle", 64'(outs()), 64'b0010100);
        repeat (20) tick();
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        chk("abort_first_word", 64'(hash[12:0]), 64'(mem[0]));
        chk_hash("abort_hash_held", h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
